// File: rtl/life_board_store.sv
// Game of Life board memory: holds the current generation plus a 2-bit saturating age per cell,
// serves an age-coloured GRB value per cell, and commits the next generation at frame end.
module life_board_store #(
    parameter int          ROWS       = 8,
    parameter int          COLS       = 8,
    parameter int          GEN_W      = 16,
    parameter logic [23:0] DEAD_COLOR = 24'h000000,
    parameter logic [23:0] AGE0_COLOR = 24'h00F000,
    parameter logic [23:0] AGE1_COLOR = 24'hF0F000,
    parameter logic [23:0] AGE2_COLOR = 24'hF00000,
    parameter logic [23:0] AGE3_COLOR = 24'h0000F0,
    localparam int         CELLS      = ROWS * COLS,
    localparam int         ADDR_W     = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_valid,
    output logic              init_ready,
    input  logic [CELLS-1:0]  init_state,
    input  logic [CELLS-1:0]  next_state,
    output logic [CELLS-1:0]  curr_state,
    input  logic [ADDR_W-1:0] read_address,
    output logic [23:0]       read_data,
    input  logic              pixel_done,
    input  logic              hold,
    output logic              frame_commit,
    output logic [GEN_W-1:0]  gen_count,
    output logic              loaded
);

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W:0]   CELLS_W  = (ADDR_W + 1)'(CELLS);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CELLS-1:0]        curr_q, curr_d;
    logic [CELLS-1:0][1:0]   age_q, age_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]       raddr_q, raddr_d;
    logic [23:0]             read_data_q, read_data_d;
    logic                    frame_commit_q, frame_commit_d;
    logic [GEN_W-1:0]        gen_q, gen_d;
    logic                    loaded_q, loaded_d;
    logic                    frame_end;
    logic                    commit;

    // A load always wins over a commit landing on the same edge.
    always_comb begin
        state_d        = state_q;
        curr_d         = curr_q;
        age_d          = age_q;
        cnt_d          = cnt_q;
        gen_d          = gen_q;
        loaded_d       = loaded_q;
        raddr_d        = read_address;
        frame_end      = (state_q == ST_RUN) && pixel_done && (cnt_q == LAST_CNT);
        commit         = frame_end && !hold && !init_valid;
        frame_commit_d = commit;

        if (init_valid) begin
            state_d  = ST_RUN;
            curr_d   = init_state;
            age_d    = '0;
            cnt_d    = '0;
            gen_d    = '0;
            loaded_d = 1'b1;
        end else if ((state_q == ST_RUN) && pixel_done) begin
            cnt_d = frame_end ? '0 : cnt_q + 1'b1;
            if (commit) begin
                curr_d = next_state;
                gen_d  = gen_q + 1'b1;
                for (int i = 0; i < CELLS; i++) begin
                    if (curr_q[i] && next_state[i]) begin
                        age_d[i] = (age_q[i] == 2'd3) ? 2'd3 : age_q[i] + 2'd1;
                    end else begin
                        age_d[i] = 2'd0;
                    end
                end
            end
        end
    end

    // Colour is looked up from the address captured on the previous edge.
    always_comb begin
        read_data_d = 24'h000000;
        if ({1'b0, raddr_q} < CELLS_W) begin
            read_data_d = DEAD_COLOR;
            if ((state_q == ST_RUN) && curr_q[raddr_q]) begin
                case (age_q[raddr_q])
                    2'd0:    read_data_d = AGE0_COLOR;
                    2'd1:    read_data_d = AGE1_COLOR;
                    2'd2:    read_data_d = AGE2_COLOR;
                    default: read_data_d = AGE3_COLOR;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            curr_q         <= '0;
            age_q          <= '0;
            cnt_q          <= '0;
            raddr_q        <= '0;
            read_data_q    <= '0;
            frame_commit_q <= 1'b0;
            gen_q          <= '0;
            loaded_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            curr_q         <= curr_d;
            age_q          <= age_d;
            cnt_q          <= cnt_d;
            raddr_q        <= raddr_d;
            read_data_q    <= read_data_d;
            frame_commit_q <= frame_commit_d;
            gen_q          <= gen_d;
            loaded_q       <= loaded_d;
        end
    end

    assign init_ready   = rst_n;
    assign curr_state   = curr_q;
    assign read_data    = read_data_q;
    assign frame_commit = frame_commit_q;
    assign gen_count    = gen_q;
    assign loaded       = loaded_q;

endmodule
